ahb3lite_sram_slave: RTL and testbench

- AHB-Lite slave that sits downstream of the core's AHB-Lite data/instruction master ports and terminates transfers into a single-port synchronous SRAM macro (1-cycle read latency).
- Zero-wait reads and posted zero-wait writes, using a one-entry write buffer with read-hit byte merging.
- Two-cycle ERROR response for illegal transfers.

---
 rtl/ahb3lite_sram_slave.sv | 145 ++++++++++++++
 tb/tb_ahb3lite_sram_slave.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_sram_slave.sv
// AHB-Lite slave in front of a 1-cycle-latency synchronous SRAM.
// Zero-wait reads, posted writes through a one-entry buffer with read-hit byte merging.
module ahb3lite_sram_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MEM_AW    = 14
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL,
   input  logic [31:0]       HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic [3:0]        HPROT,
   input  logic              HMASTLOCK,
   input  logic [31:0]       HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [31:0]       HRDATA,
   output logic              sram_cs,
   output logic              sram_we,
   output logic [3:0]        sram_be,
   output logic [MEM_AW-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata
);

   // state   | meaning
   // D_IDLE  | no data phase pending
   // D_READ  | read data phase, HRDATA from SRAM merged with buffer
   // D_WRITE | write data phase, HWDATA loads buffer when ready
   // D_ERR1  | first error cycle, HREADYOUT=0
   // D_ERR2  | second error cycle, HREADYOUT=1
   typedef enum logic [2:0] {D_IDLE, D_READ, D_WRITE, D_ERR1, D_ERR2} dstate_t;

   dstate_t           r_dstate;
   logic              r_buf_valid;
   logic [MEM_AW-1:0] r_buf_addr;
   logic [3:0]        r_buf_be;
   logic [31:0]       r_buf_data;
   logic [MEM_AW-1:0] r_wr_addr;
   logic [3:0]        r_wr_be;
   logic [MEM_AW-1:0] r_rd_addr;

   logic [31:0]       w_off;
   logic              w_in_range;
   logic [MEM_AW-1:0] w_waddr;
   logic [3:0]        w_be;
   logic              w_illegal;
   logic              w_req;
   logic              w_acc;
   logic              w_rd_req;
   logic              w_rd_issue;
   logic              w_conflict;
   logic              w_wr_done;
   logic              w_drain;
   logic [31:0]       w_merged;
   logic              w_unused;

   assign w_off      = HADDR - BASE_ADDR;
   assign w_in_range = (w_off >> (MEM_AW + 2)) == 32'd0;
   assign w_waddr    = w_off[MEM_AW+1:2];

   always_comb begin
      w_be = 4'hF;
      case (HSIZE)
         3'd0:    w_be = 4'b0001 << HADDR[1:0];
         3'd1:    w_be = 4'b0011 << HADDR[1:0];
         default: w_be = 4'hF;
      endcase
   end

   assign w_illegal = (HSIZE > 3'd2)
                    | ((HSIZE == 3'd1) & HADDR[0])
                    | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'd0))
                    | !w_in_range;

   assign w_req      = HSEL & HTRANS[1];
   assign w_acc      = w_req & HREADY;
   assign w_rd_req   = w_req & !HWRITE & !w_illegal;
   // A read arriving while the buffer is full and a write data phase is open would need
   // the single SRAM port twice; stall one cycle so the buffer can drain first.
   assign w_conflict = r_buf_valid & (r_dstate == D_WRITE) & w_rd_req;
   assign w_rd_issue = w_rd_req & HREADY & !w_conflict;
   assign w_drain    = r_buf_valid & !w_rd_issue;

   assign HREADYOUT  = (r_dstate != D_ERR1) & !w_conflict;
   assign HRESP      = (r_dstate == D_ERR1) | (r_dstate == D_ERR2);
   assign w_wr_done  = (r_dstate == D_WRITE) & HREADYOUT;

   // Gated by reset so a discarded buffer entry never reaches the SRAM.
   assign sram_cs    = !HRESET & (w_rd_issue | w_drain);
   assign sram_we    = !HRESET & w_drain;
   assign sram_addr  = w_rd_issue ? w_waddr : r_buf_addr;
   assign sram_be    = w_rd_issue ? w_be : r_buf_be;
   assign sram_wdata = r_buf_data;

   always_comb begin
      w_merged = sram_rdata;
      for (int i = 0; i < 4; i++) begin
         if (r_buf_valid && (r_buf_addr == r_rd_addr) && r_buf_be[i])
            w_merged[8*i +: 8] = r_buf_data[8*i +: 8];
      end
   end

   assign HRDATA   = (r_dstate == D_READ) ? w_merged : 32'd0;
   assign w_unused = &{1'b0, HBURST, HPROT, HMASTLOCK, HTRANS[0], w_off[1:0]};

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_dstate    <= D_IDLE;
         r_buf_valid <= 1'b0;
      end else begin
         if (r_dstate == D_ERR1)
            r_dstate <= D_ERR2;
         else if (HREADYOUT) begin
            if (!w_acc)         r_dstate <= D_IDLE;
            else if (w_illegal) r_dstate <= D_ERR1;
            else if (HWRITE)    r_dstate <= D_WRITE;
            else                r_dstate <= D_READ;
         end

         if (HREADYOUT && w_acc && !w_illegal) begin
            if (HWRITE) begin
               r_wr_addr <= w_waddr;
               r_wr_be   <= w_be;
            end else begin
               r_rd_addr <= w_waddr;
            end
         end

         if (w_wr_done) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= r_wr_addr;
            r_buf_be    <= r_wr_be;
            r_buf_data  <= HWDATA;
         end else if (w_drain) begin
            r_buf_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench for ahb3lite_sram_slave: per-cycle expected responses are queued by the
// stimulus and compared by an independent monitor on the falling edge.
module tb_ahb3lite_sram_slave;

   localparam logic [31:0] B  = 32'h2000_0000;
   localparam logic [1:0]  ID = 2'd0, BZ = 2'd1, NS = 2'd2, SQ = 2'd3;
   localparam logic [2:0]  BY = 3'd0, HF = 3'd1, WD = 3'd2;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        HSEL = 1'b0;
   logic [31:0] HADDR = 32'd0;
   logic [1:0]  HTRANS = ID;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = WD;
   logic [31:0] HWDATA = 32'd0;
   wire  logic  HREADY;
   logic        HREADYOUT, HRESP;
   logic [31:0] HRDATA;
   logic        sram_cs, sram_we;
   logic [3:0]  sram_be;
   logic [9:0]  sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata = 32'd0;

   logic [31:0] mem [0:1023];

   typedef struct packed {
      int          n;
      logic        rdy;
      logic        resp;
      logic [31:0] rd;
      logic        cs;
      logic        we;
      logic [9:0]  sa;
      logic [3:0]  be;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc_n  = 0;

   assign HREADY = HREADYOUT;

   ahb3lite_sram_slave #(.BASE_ADDR(B), .MEM_AW(10)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'd0), .HPROT(4'd0), .HMASTLOCK(1'b0),
      .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
      .HRDATA(HRDATA), .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) begin
      if (sram_cs && !sram_we) sram_rdata <= mem[sram_addr];
      if (sram_cs && sram_we)
         for (int i = 0; i < 4; i++)
            if (sram_be[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
   end

   task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, n, act, exp);
      end
   endtask

   always @(negedge HCLK) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("hreadyout", e.n, {31'd0, HREADYOUT}, {31'd0, e.rdy});
         chk("hresp",     e.n, {31'd0, HRESP},     {31'd0, e.resp});
         chk("hrdata",    e.n, HRDATA,             e.rd);
         chk("sram_cs",   e.n, {31'd0, sram_cs},   {31'd0, e.cs});
         chk("sram_we",   e.n, {31'd0, sram_we},   {31'd0, e.we});
         if (e.cs) begin
            chk("sram_addr", e.n, {22'd0, sram_addr}, {22'd0, e.sa});
            chk("sram_be",   e.n, {28'd0, sram_be},   {28'd0, e.be});
         end
      end
   end

   task automatic cyc(input logic rst, input logic s, input logic [1:0] t, input logic w,
                      input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                      input logic e_rdy, input logic e_resp, input logic [31:0] e_rd,
                      input logic e_cs, input logic e_we, input logic [9:0] e_sa,
                      input logic [3:0] e_be);
      exp_t e;
      @(posedge HCLK);
      #1;
      HRESET = rst; HSEL = s; HTRANS = t; HWRITE = w; HSIZE = sz; HADDR = a; HWDATA = wd;
      cyc_n++;
      e = '{n: cyc_n, rdy: e_rdy, resp: e_resp, rd: e_rd, cs: e_cs, we: e_we, sa: e_sa, be: e_be};
      q.push_back(e);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      mem[20] = 32'h0BAD_F00D;
      repeat (2) @(posedge HCLK);
      cyc(1, 0, ID, 0, WD, 32'd0, 32'd0, 1, 0, 32'd0, 0, 0, 0, 4'h0);

      // word write, drain during IDLE, zero-wait read back
      cyc(0, 1, NS, 1, WD, B + 32'h10, 32'd0,        1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'hDEAD_BEEF,     1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             1, 0, 32'd0, 1, 1, 4, 4'hF);
      cyc(0, 1, NS, 0, WD, B + 32'h10, 32'd0,        1, 0, 32'd0, 1, 0, 4, 4'hF);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             1, 0, 32'hDEAD_BEEF, 0, 0, 0, 4'h0);

      // byte write then immediate read of the same word: merge
      mem[4] = 32'h1122_3344;
      cyc(0, 1, NS, 1, BY, B + 32'h11, 32'd0,        1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, NS, 0, WD, B + 32'h10, 32'h0000_AA00, 1, 0, 32'd0, 1, 0, 4, 4'hF);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             1, 0, 32'h1122_AA44, 1, 1, 4, 4'b0010);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             1, 0, 32'd0, 0, 0, 0, 4'h0);

      // pending entry, write A then read B: one stall cycle
      cyc(0, 1, NS, 1, WD, B + 32'h20, 32'd0,        1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, NS, 1, WD, B + 32'h40, 32'hCAFE_F00D, 1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, NS, 0, WD, B + 32'h20, 32'h1234_5678, 0, 0, 32'd0, 1, 1, 8, 4'hF);
      cyc(0, 1, NS, 0, WD, B + 32'h20, 32'h1234_5678, 1, 0, 32'd0, 1, 0, 8, 4'hF);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             1, 0, 32'hCAFE_F00D, 1, 1, 16, 4'hF);
      cyc(0, 1, NS, 0, WD, B + 32'h40, 32'd0,        1, 0, 32'd0, 1, 0, 16, 4'hF);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             1, 0, 32'h1234_5678, 0, 0, 0, 4'h0);

      // write -> write -> write back-to-back, no stall
      cyc(0, 1, NS, 1, WD, B + 32'h30, 32'd0,        1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, NS, 1, HF, B + 32'h36, 32'hA1A1_A1A1, 1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, NS, 1, WD, B + 32'h38, 32'hB2B2_0000, 1, 0, 32'd0, 1, 1, 12, 4'hF);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'hC3C3_C3C3,     1, 0, 32'd0, 1, 1, 13, 4'hC);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             1, 0, 32'd0, 1, 1, 14, 4'hF);
      cyc(0, 1, NS, 0, HF, B + 32'h36, 32'd0,        1, 0, 32'd0, 1, 0, 13, 4'hC);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             1, 0, 32'hB2B2_0000, 0, 0, 0, 4'h0);

      // illegal transfers: misaligned half, misaligned word, HSIZE=3, above and below window
      cyc(0, 1, NS, 1, HF, B + 32'h3, 32'd0,         1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             0, 1, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, NS, 0, WD, B + 32'h2, 32'd0,         1, 1, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             0, 1, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, NS, 0, 3'd3, B, 32'd0,               1, 1, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             0, 1, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, NS, 0, WD, B + 32'h1000, 32'd0,      1, 1, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             0, 1, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             1, 1, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, NS, 0, WD, B - 32'h4, 32'd0,         1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             0, 1, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             1, 1, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             1, 0, 32'd0, 0, 0, 0, 4'h0);

      // reset with a valid buffer entry discards it
      cyc(0, 1, NS, 1, WD, B + 32'h50, 32'd0,        1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'h55AA_55AA,     1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(1, 1, ID, 0, WD, 32'd0, 32'd0,             1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, NS, 0, WD, B + 32'h50, 32'd0,        1, 0, 32'd0, 1, 0, 20, 4'hF);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             1, 0, 32'h0BAD_F00D, 0, 0, 0, 4'h0);

      // unselected, BUSY and IDLE cycles are OKAY with no SRAM access; SEQ is accepted
      cyc(0, 0, NS, 0, WD, B + 32'h10, 32'd0,        1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, BZ, 0, WD, B + 32'h10, 32'd0,        1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 0, NS, 1, WD, B + 32'h10, 32'd0,        1, 0, 32'd0, 0, 0, 0, 4'h0);
      cyc(0, 1, SQ, 0, WD, B + 32'h10, 32'd0,        1, 0, 32'd0, 1, 0, 4, 4'hF);
      cyc(0, 1, ID, 0, WD, 32'd0, 32'd0,             1, 0, 32'h1122_AA44, 0, 0, 0, 4'h0);

      for (int k = 0; k < 10 && q.size() != 0; k++) begin
         @(negedge HCLK);
         #1;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d expectations left, expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
